// File: rtl/sample_window_pkg.sv
// Shared types and constants for the sample_window capture buffer.
package sample_window_pkg;

  // Capture FSM: filling the ring for the first time, live capture, frozen readout.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LIVE  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width of the saturating lost-strobe counter.
  localparam int DROP_W = 16;

  // Bit position of channel 'chan' inside a packed frame of 'width'-bit samples.
  function automatic int chan_lsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/sample_window_if.sv
// Sample input, snapshot control, status and readout stream of sample_window.
interface sample_window_if
  import sample_window_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 256
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int FRAME_W = WIDTH * CHANNELS;

  logic               ready_in;
  logic [FRAME_W-1:0] signal_in;
  logic               snapshot_in;
  logic [ADDR_W-1:0]  offset_out;
  logic               full_out;
  logic               busy_out;
  logic               frame_valid_out;
  logic               frame_ready_in;
  logic [FRAME_W-1:0] frame_data_out;
  logic               frame_last_out;
  logic [DROP_W-1:0]  dropped_out;

  // Upstream/downstream side: drives samples, snapshots and readout backpressure.
  modport master (
    output ready_in, signal_in, snapshot_in, frame_ready_in,
    input  offset_out, full_out, busy_out, frame_valid_out,
           frame_data_out, frame_last_out, dropped_out
  );

  // Capture buffer side.
  modport slave (
    input  ready_in, signal_in, snapshot_in, frame_ready_in,
    output offset_out, full_out, busy_out, frame_valid_out,
           frame_data_out, frame_last_out, dropped_out
  );

endinterface

// File: rtl/sample_window_ram.sv
// Simple dual-port frame store: one write port, one read port with a registered output.
module sample_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              rd_en_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic [DATA_W-1:0] rd_data_out
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage write and one-cycle registered read; contents are never cleared.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) mem[wr_addr_in] <= wr_data_in;
    if (rd_en_in) rd_data_q <= mem[rd_addr_in];
  end

  assign rd_data_out = rd_data_q;

endmodule

// File: rtl/sample_window.sv
// Multi-channel circular capture buffer: records frames into a ring and, on a
// snapshot, freezes it and streams the last DEPTH frames oldest-first.
module sample_window
  import sample_window_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 256,
  parameter int CHANNELS = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  sample_window_if.slave bus
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int FRAME_W = WIDTH * CHANNELS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  ALL_READ  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_READ = CNT_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  offset_q, offset_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic               full_q, full_d;
  logic               pending_q, pending_d;
  logic [DROP_W-1:0]  dropped_q, dropped_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic               out_valid_q, out_valid_d;
  logic [FRAME_W-1:0] out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               skid_valid_q, skid_valid_d;
  logic [FRAME_W-1:0] skid_data_q, skid_data_d;
  logic               skid_last_q, skid_last_d;

  logic               wr_en;
  logic               rd_en;
  logic               pop;
  logic               start_drain;
  logic [1:0]         occupancy;
  logic [FRAME_W-1:0] ram_rd_data;

  sample_ram #(
    .DATA_W (FRAME_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_in      (clk_in),
    .wr_en_in    (wr_en),
    .wr_addr_in  (offset_q),
    .wr_data_in  (bus.signal_in),
    .rd_en_in    (rd_en),
    .rd_addr_in  (rd_ptr_q),
    .rd_data_out (ram_rd_data)
  );

  assign pop = out_valid_q && bus.frame_ready_in;
  assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q};

  // Capture FSM: ring writes, fill tracking, snapshot arming, drop counting and read issue.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    count_d     = count_q;
    full_d      = full_q;
    pending_d   = pending_q;
    dropped_d   = dropped_q;
    rd_ptr_d    = rd_ptr_q;
    issued_d    = issued_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    start_drain = 1'b0;

    unique case (state_q)
      FILL: begin
        if (bus.snapshot_in) pending_d = 1'b1;
        if (bus.ready_in) begin
          wr_en    = 1'b1;
          offset_d = offset_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == LAST_ADDR) begin
            full_d = 1'b1;
            if (pending_q || bus.snapshot_in) begin
              start_drain = 1'b1;
            end else begin
              state_d = LIVE;
            end
          end
        end
      end
      LIVE: begin
        if (bus.ready_in) begin
          wr_en    = 1'b1;
          offset_d = offset_q + 1'b1;
        end
        if (bus.snapshot_in) start_drain = 1'b1;
      end
      DRAIN: begin
        if (bus.ready_in && (dropped_q != {DROP_W{1'b1}})) dropped_d = dropped_q + 1'b1;
        if ((issued_q != ALL_READ) && ((occupancy - {1'b0, pop}) < 2'd2)) begin
          rd_en      = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          issued_d   = issued_q + 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = (issued_q == LAST_READ);
        end
        if (pop && out_last_q) state_d = LIVE;
      end
      default: state_d = FILL;
    endcase

    if (start_drain) begin
      state_d   = DRAIN;
      pending_d = 1'b0;
      dropped_d = '0;
      rd_ptr_d  = offset_d;
      issued_d  = '0;
    end
  end

  // Readout path: RAM data lands in the output register, or in the skid entry while stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = rd_valid_q;
        skid_data_d  = ram_rd_data;
        skid_last_d  = rd_last_q;
      end else if (rd_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rd_data;
        out_last_d  = rd_last_q;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (rd_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_rd_data;
      skid_last_d  = rd_last_q;
    end
  end

  // State, pointer and readout registers; reset drops the stream immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= FILL;
      offset_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      pending_q    <= 1'b0;
      dropped_q    <= '0;
      rd_ptr_q     <= '0;
      issued_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      count_q      <= count_d;
      full_q       <= full_d;
      pending_q    <= pending_d;
      dropped_q    <= dropped_d;
      rd_ptr_q     <= rd_ptr_d;
      issued_q     <= issued_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign bus.offset_out      = offset_q;
  assign bus.full_out        = full_q;
  assign bus.busy_out        = pending_q || (state_q == DRAIN);
  assign bus.frame_valid_out = out_valid_q;
  assign bus.frame_data_out  = out_data_q;
  assign bus.frame_last_out  = out_last_q;
  assign bus.dropped_out     = dropped_q;

endmodule

// File: tb/tb_sample_window.sv
// Self-checking bench for sample_window against a queue-based model of the
// frames written since reset.
module tb_sample_window;
  import sample_window_pkg::*;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 256;
  localparam int CHANNELS = 2;
  localparam int FRAME_W  = WIDTH * CHANNELS;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  sample_window_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

  sample_window #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Free-running clock.
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int fails  = 0;
  int ramp_n = 0;
  logic [FRAME_W-1:0] written [$];

  // Compare one observed value against the model and count the result.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Ramp frame: channel 0 carries n, channel 1 carries -n.
  function automatic logic [FRAME_W-1:0] rampFrame(input int n);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int c = 0; c < CHANNELS; c++)
      f[chan_lsb(c, WIDTH) +: WIDTH] = (c % 2 == 0) ? WIDTH'(n) : WIDTH'(-n);
    return f;
  endfunction

  function automatic logic [FRAME_W-1:0] randFrame();
    logic [FRAME_W-1:0] f;
    for (int c = 0; c < CHANNELS; c++) f[chan_lsb(c, WIDTH) +: WIDTH] = WIDTH'($urandom);
    return f;
  endfunction

  // Offset and full follow purely from how many frames were written since reset.
  task automatic checkStatus(input string tag);
    checkOutput({tag, "_offset"}, 64'(bus.offset_out), 64'(written.size() % DEPTH));
    checkOutput({tag, "_full"}, 64'(bus.full_out), 64'(written.size() >= DEPTH));
  endtask

  // Apply reset, check the idle outputs, and clear the model.
  task automatic doReset();
    bus.ready_in       = 1'b0;
    bus.signal_in      = '0;
    bus.snapshot_in    = 1'b0;
    bus.frame_ready_in = 1'b0;
    rst_in = 1'b1;
    step();
    step();
    checkOutput("rst_offset", 64'(bus.offset_out), 64'd0);
    checkOutput("rst_full", 64'(bus.full_out), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy_out), 64'd0);
    checkOutput("rst_valid", 64'(bus.frame_valid_out), 64'd0);
    checkOutput("rst_last", 64'(bus.frame_last_out), 64'd0);
    checkOutput("rst_data", 64'(bus.frame_data_out), 64'd0);
    checkOutput("rst_dropped", 64'(bus.dropped_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    written.delete();
    ramp_n = 0;
  endtask

  // Feed 'count' accepted strobes (ramp or random data) with optional idle gaps.
  task automatic applyStimulus(input int count, input bit use_ramp, input int gap_pct);
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < count; i++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        bus.ready_in = 1'b0;
        step();
      end
      f = use_ramp ? rampFrame(ramp_n) : randFrame();
      if (use_ramp) ramp_n++;
      bus.ready_in  = 1'b1;
      bus.signal_in = f;
      checkOutput("fill_valid", 64'(bus.frame_valid_out), 64'd0);
      written.push_back(f);
      step();
    end
    bus.ready_in = 1'b0;
  endtask

  // One-cycle snapshot pulse, optionally with a sample in the same cycle.
  task automatic issueSnapshot(input bit with_sample);
    logic [FRAME_W-1:0] f;
    bus.snapshot_in = 1'b1;
    if (with_sample) begin
      f = randFrame();
      bus.ready_in  = 1'b1;
      bus.signal_in = f;
      written.push_back(f);
    end
    step();
    bus.snapshot_in = 1'b0;
    bus.ready_in    = 1'b0;
  endtask

  // Consume the readout stream from DRAIN entry; mode 0 always ready, 1 toggling, 2 random.
  task automatic drainLoop(input int mode, input int drops, input int stop_at, input int snap_at);
    logic [FRAME_W-1:0] exp_frames [$];
    int idx = 0;
    int k = 0;
    int first_valid = -1;
    int bubbles = 0;
    int drop_done = 0;
    for (int i = 0; i < DEPTH; i++) exp_frames.push_back(written[written.size() - DEPTH + i]);
    while (idx < stop_at && k < 4 * DEPTH + 32) begin
      case (mode)
        0:       bus.frame_ready_in = 1'b1;
        1:       bus.frame_ready_in = (k % 2 == 0);
        default: bus.frame_ready_in = 1'($urandom_range(1));
      endcase
      bus.ready_in    = (drop_done < drops);
      bus.signal_in   = randFrame();
      if (drop_done < drops) drop_done++;
      bus.snapshot_in = (k == snap_at);
      checkOutput("drain_busy", 64'(bus.busy_out), 64'd1);
      if (bus.frame_valid_out) begin
        if (first_valid < 0) first_valid = k;
        checkOutput("drain_data", 64'(bus.frame_data_out), 64'(exp_frames[idx]));
        checkOutput("drain_last", 64'(bus.frame_last_out), 64'(idx == DEPTH - 1));
        if (bus.frame_ready_in) idx++;
      end else if (first_valid >= 0) begin
        bubbles++;
      end
      step();
      k++;
    end
    bus.ready_in       = 1'b0;
    bus.snapshot_in    = 1'b0;
    bus.frame_ready_in = 1'b0;
    checkOutput("drain_count", 64'(idx), 64'(stop_at));
    if (stop_at == DEPTH) begin
      checkOutput("drain_latency", 64'(first_valid), 64'd2);
      if (mode == 0) checkOutput("drain_bubbles", 64'(bubbles), 64'd0);
      checkOutput("post_busy", 64'(bus.busy_out), 64'd0);
      checkOutput("post_valid", 64'(bus.frame_valid_out), 64'd0);
      checkOutput("post_dropped", 64'(bus.dropped_out), 64'(drops));
      checkStatus("post");
    end
  endtask

  // Directed sequence of scenarios with randomized data, gaps and backpressure.
  initial begin
    $display("[TB] start");

    // Ramp fill of exactly DEPTH frames, full-rate readout.
    doReset();
    applyStimulus(DEPTH, 1'b1, 0);
    checkStatus("t1_fill");
    issueSnapshot(1'b0);
    drainLoop(0, 0, DEPTH, -1);

    // Ring wraps past DEPTH; readout starts at the oldest surviving frame.
    doReset();
    applyStimulus(300, 1'b1, 20);
    checkStatus("t2_fill");
    issueSnapshot(1'b0);
    drainLoop(2, 0, DEPTH, -1);

    // Snapshot during the first fill stays pending until the ring is full.
    doReset();
    applyStimulus(10, 1'b1, 0);
    issueSnapshot(1'b0);
    checkOutput("t3_pending_busy", 64'(bus.busy_out), 64'd1);
    checkOutput("t3_pending_valid", 64'(bus.frame_valid_out), 64'd0);
    applyStimulus(DEPTH - 10, 1'b1, 10);
    drainLoop(0, 0, DEPTH, -1);

    // Backpressure toggling every cycle.
    applyStimulus(40, 1'b0, 25);
    issueSnapshot(1'b0);
    drainLoop(1, 0, DEPTH, -1);

    // Sample coincident with snapshot, strobes and a snapshot during readout.
    applyStimulus(30, 1'b0, 0);
    issueSnapshot(1'b1);
    drainLoop(2, 20, DEPTH, 7);
    applyStimulus(30, 1'b0, 15);
    issueSnapshot(1'b0);
    drainLoop(0, 0, DEPTH, -1);

    // Reset in the middle of a readout, then a pending snapshot across a fresh fill.
    doReset();
    applyStimulus(DEPTH, 1'b1, 0);
    issueSnapshot(1'b0);
    drainLoop(0, 0, 100, -1);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 64'(bus.frame_valid_out), 64'd0);
    checkOutput("t6_rst_busy", 64'(bus.busy_out), 64'd0);
    checkOutput("t6_rst_full", 64'(bus.full_out), 64'd0);
    checkOutput("t6_rst_offset", 64'(bus.offset_out), 64'd0);
    checkOutput("t6_rst_data", 64'(bus.frame_data_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    written.delete();
    ramp_n = 0;
    step();
    issueSnapshot(1'b0);
    checkOutput("t6_refill_busy", 64'(bus.busy_out), 64'd1);
    applyStimulus(50, 1'b0, 10);
    checkStatus("t6_partial");
    checkOutput("t6_partial_valid", 64'(bus.frame_valid_out), 64'd0);
    applyStimulus(DEPTH - 50, 1'b0, 10);
    drainLoop(2, 0, DEPTH, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
